// File: rtl/sdram_pkg.sv
// Shared definitions for the SDR SDRAM responder: command encodings, address
// field positions, err bit indices, init state enum and read pipeline payloads.
package sdram_pkg;

    localparam int unsigned DQ_W      = 16;
    localparam int unsigned ADDR_W    = 13;
    localparam int unsigned BA_W      = 2;
    localparam int unsigned NUM_BANKS = 4;
    localparam int unsigned ROW_W     = 12;
    localparam int unsigned COL_W     = 8;
    localparam int unsigned FULL_AW   = BA_W + ROW_W + COL_W;

    // sd_addr bit 10: all-banks on PRECHARGE, auto-precharge on READ/WRITE
    localparam int unsigned A10         = 10;
    localparam int unsigned MODE_CL_LSB = 4;
    localparam int unsigned MODE_BL_LSB = 0;
    localparam int unsigned MODE_F_W    = 3;

    localparam logic [MODE_F_W-1:0] CL_2     = 3'd2;
    localparam logic [MODE_F_W-1:0] CL_3     = 3'd3;
    localparam logic [MODE_F_W-1:0] CL_RESET = CL_3;
    localparam logic [MODE_F_W-1:0] BL_ONE   = 3'd0;

    localparam int unsigned ERR_W           = 6;
    localparam int unsigned ERR_BEFORE_INIT = 0;
    localparam int unsigned ERR_IDLE_BANK   = 1;
    localparam int unsigned ERR_ACT_ACTIVE  = 2;
    localparam int unsigned ERR_TRCD        = 3;
    localparam int unsigned ERR_BAD_MODE    = 4;
    localparam int unsigned ERR_REF_ACTIVE  = 5;

    // {ras_n, cas_n, we_n}
    typedef enum logic [2:0] {
        CMD_LOAD_MODE    = 3'b000,
        CMD_AUTO_REFRESH = 3'b001,
        CMD_PRECHARGE    = 3'b010,
        CMD_ACTIVE       = 3'b011,
        CMD_WRITE        = 3'b100,
        CMD_READ         = 3'b101,
        CMD_BURST_TERM   = 3'b110,
        CMD_NOP          = 3'b111
    } cmd_e;

    typedef enum logic [1:0] {
        INIT_PRE  = 2'd0,
        INIT_REF  = 2'd1,
        INIT_MODE = 2'd2,
        READY     = 2'd3
    } init_state_e;

    // Read captured at the command edge
    typedef struct packed {
        logic       valid;
        logic       cl3;
        logic [1:0] dqm;
    } rd_tag_t;

    // Extra delay stage used only by CL=3 reads
    typedef struct packed {
        logic            valid;
        logic [1:0]      dqm;
        logic [DQ_W-1:0] data;
    } rd_beat_t;

    function automatic logic mode_ok(input logic [MODE_F_W-1:0] cl,
                                     input logic [MODE_F_W-1:0] bl);
        return ((cl == CL_2) || (cl == CL_3)) && (bl == BL_ONE);
    endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// Backing store: 2^AW x 16 synchronous RAM, one byte-enabled write port and one
// registered read port. Contents are not reset.
//   clk      : clock
//   wr_addr  : write word address
//   wr_be    : byte enables, bit1 = data[15:8], bit0 = data[7:0]
//   wr_data  : write data
//   rd_en    : read strobe, rd_data updates on the following edge
//   rd_addr  : read word address
//   rd_data  : registered read data
module sdram_resp_mem #(
    parameter int unsigned AW = 16
) (
    input  logic          clk,
    input  logic [AW-1:0] wr_addr,
    input  logic [1:0]    wr_be,
    input  logic [15:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [15:0]   rd_data
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [7:0] mem_lo [DEPTH];
    logic [7:0] mem_hi [DEPTH];

    // Write and read share the edge; a read of the word written one edge earlier sees new data
    always_ff @(posedge clk) begin
        if (wr_be[0]) mem_lo[wr_addr] <= wr_data[7:0];
        if (wr_be[1]) mem_hi[wr_addr] <= wr_data[15:8];
        if (rd_en)    rd_data         <= {mem_hi[rd_addr], mem_lo[rd_addr]};
    end

endmodule

// File: rtl/sdram_responder.sv
// Synthesizable SDR SDRAM device model backed by on-chip RAM. Decodes the
// controller's command bus, tracks init sequence, mode register, per-bank open
// rows, CAS latency and auto-precharge.
// Optional: define SDRAM_RESP_CHECK_EN to build the protocol checker (err flags,
// per-bank TRCD counters, gating of accesses before init). Undefined: err = 0
// and accesses before init are executed.
//   clk, reset          : clock, synchronous active-high reset
//   sd_cs_n..sd_we_n    : command strobes (active-low)
//   sd_ba, sd_addr      : bank, row/column/mode address
//   sd_dqm, sd_dq_in    : byte masks, write data
//   sd_dq_out, sd_dq_oe : read data and per-byte output enable
//   init_done           : init sequence completed
//   refresh_cnt         : AUTO_REFRESH count since init_done
//   err                 : sticky protocol-violation flags
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int unsigned MEM_AW = 16,
    parameter int unsigned TRCD   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sd_cs_n,
    input  logic              sd_ras_n,
    input  logic              sd_cas_n,
    input  logic              sd_we_n,
    input  logic [1:0]        sd_ba,
    input  logic [12:0]       sd_addr,
    input  logic [1:0]        sd_dqm,
    input  logic [15:0]       sd_dq_in,
    output logic [15:0]       sd_dq_out,
    output logic [1:0]        sd_dq_oe,
    output logic              init_done,
    output logic [15:0]       refresh_cnt,
    output logic [ERR_W-1:0]  err
);

    init_state_e           init_state;
    logic                  ref_seen;
    logic [MODE_F_W-1:0]   cl_q;
    logic [MODE_F_W-1:0]   bl_q;
    logic [NUM_BANKS-1:0]  bank_active;
    logic [ROW_W-1:0]      bank_row [NUM_BANKS];
    rd_tag_t               rd_tag;
    rd_beat_t              rd_beat;
    logic [DQ_W-1:0]       mem_q;

    cmd_e                  cmd_c;
    logic                  exec_ok_c;
    logic                  rd_cmd_c;
    logic                  wr_cmd_c;
    logic                  mode_ok_c;
    logic [MODE_F_W-1:0]   mode_cl_c;
    logic [MODE_F_W-1:0]   mode_bl_c;
    logic [FULL_AW-1:0]    full_addr_c;
    logic [MEM_AW-1:0]     mem_addr_c;
    logic [1:0]            wr_be_c;

    // Command decode; deselected bus is treated as NOP
    assign cmd_c     = sd_cs_n ? CMD_NOP : cmd_e'({sd_ras_n, sd_cas_n, sd_we_n});
    assign mode_cl_c = sd_addr[MODE_CL_LSB +: MODE_F_W];
    assign mode_bl_c = sd_addr[MODE_BL_LSB +: MODE_F_W];
    assign mode_ok_c = mode_ok(mode_cl_c, mode_bl_c);

`ifdef SDRAM_RESP_CHECK_EN
    assign exec_ok_c = (init_state == READY);
`else
    assign exec_ok_c = 1'b1;
`endif

    assign rd_cmd_c    = (cmd_c == CMD_READ)  && exec_ok_c;
    assign wr_cmd_c    = (cmd_c == CMD_WRITE) && exec_ok_c;
    // Accesses always use the bank's last latched row, even if the bank is idle
    assign full_addr_c = {sd_ba, bank_row[sd_ba], sd_addr[COL_W-1:0]};
    assign mem_addr_c  = MEM_AW'(full_addr_c);
    assign wr_be_c     = wr_cmd_c ? ~sd_dqm : 2'b00;

    sdram_resp_mem #(
        .AW (MEM_AW)
    ) u_mem (
        .clk     (clk),
        .wr_addr (mem_addr_c),
        .wr_be   (wr_be_c),
        .wr_data (sd_dq_in),
        .rd_en   (rd_cmd_c),
        .rd_addr (mem_addr_c),
        .rd_data (mem_q)
    );

    // Init FSM, mode register, bank table, refresh counter and CL pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            init_state  <= INIT_PRE;
            ref_seen    <= 1'b0;
            init_done   <= 1'b0;
            refresh_cnt <= '0;
            cl_q        <= CL_RESET;
            bl_q        <= BL_ONE;
            bank_active <= '0;
            for (int unsigned b = 0; b < NUM_BANKS; b++) bank_row[b] <= '0;
            rd_tag      <= '0;
            rd_beat     <= '0;
            sd_dq_out   <= '0;
            sd_dq_oe    <= 2'b00;
        end else begin
            // RAM data is available one edge after READ: CL=2 drives it out
            // directly, CL=3 holds it one more stage first
            rd_tag.valid  <= rd_cmd_c;
            rd_tag.cl3    <= (cl_q == CL_3);
            rd_tag.dqm    <= sd_dqm;
            rd_beat.valid <= rd_tag.valid && rd_tag.cl3;
            rd_beat.dqm   <= rd_tag.dqm;
            rd_beat.data  <= mem_q;

            if (rd_beat.valid) begin
                sd_dq_out <= rd_beat.data;
                sd_dq_oe  <= ~rd_beat.dqm;
            end else if (rd_tag.valid && !rd_tag.cl3) begin
                sd_dq_out <= mem_q;
                sd_dq_oe  <= ~rd_tag.dqm;
            end else begin
                sd_dq_oe  <= 2'b00;
            end

            case (cmd_c)
                CMD_LOAD_MODE: begin
                    if (mode_ok_c) begin
                        cl_q <= mode_cl_c;
                        bl_q <= mode_bl_c;
                        if (init_state == INIT_MODE) begin
                            init_state <= READY;
                            init_done  <= 1'b1;
                        end
                    end
                end
                CMD_PRECHARGE: begin
                    if (sd_addr[A10]) begin
                        bank_active <= '0;
                        if (init_state == INIT_PRE) init_state <= INIT_REF;
                    end else begin
                        bank_active[sd_ba] <= 1'b0;
                    end
                end
                CMD_AUTO_REFRESH: begin
                    if (init_state == READY) begin
                        refresh_cnt <= refresh_cnt + 16'd1;
                    end else if (init_state == INIT_REF) begin
                        if (ref_seen) begin
                            init_state <= INIT_MODE;
                            ref_seen   <= 1'b0;
                        end else begin
                            ref_seen   <= 1'b1;
                        end
                    end
                end
                CMD_ACTIVE: begin
                    if (exec_ok_c) begin
                        bank_active[sd_ba] <= 1'b1;
                        bank_row[sd_ba]    <= sd_addr[ROW_W-1:0];
                    end
                end
                CMD_READ, CMD_WRITE: begin
                    if (exec_ok_c && sd_addr[A10]) bank_active[sd_ba] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef SDRAM_RESP_CHECK_EN
    localparam int unsigned TRCD_W    = (TRCD > 1) ? $clog2(TRCD) : 1;
    localparam int unsigned TRCD_LOAD = (TRCD > 0) ? TRCD - 1 : 0;

    logic [TRCD_W-1:0] trcd_cnt [NUM_BANKS];
    logic [ERR_W-1:0]  err_set_c;

    // Cycles remaining before the bank may be accessed; 0 means legal
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) trcd_cnt[b] <= '0;
        end else begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                if ((cmd_c == CMD_ACTIVE) && exec_ok_c && (sd_ba == BA_W'(b)))
                    trcd_cnt[b] <= TRCD_W'(TRCD_LOAD);
                else if (trcd_cnt[b] != '0)
                    trcd_cnt[b] <= trcd_cnt[b] - TRCD_W'(1);
            end
        end
    end

    // Violations detected by the current command
    always_comb begin
        err_set_c = '0;
        case (cmd_c)
            CMD_ACTIVE: begin
                if (!exec_ok_c)               err_set_c[ERR_BEFORE_INIT] = 1'b1;
                else if (bank_active[sd_ba])  err_set_c[ERR_ACT_ACTIVE]  = 1'b1;
            end
            CMD_READ, CMD_WRITE: begin
                if (!exec_ok_c)               err_set_c[ERR_BEFORE_INIT] = 1'b1;
                else if (!bank_active[sd_ba]) err_set_c[ERR_IDLE_BANK]   = 1'b1;
                else if (trcd_cnt[sd_ba] != '0) err_set_c[ERR_TRCD]      = 1'b1;
            end
            CMD_LOAD_MODE: begin
                if (!mode_ok_c)               err_set_c[ERR_BAD_MODE]    = 1'b1;
            end
            CMD_AUTO_REFRESH: begin
                if (|bank_active)             err_set_c[ERR_REF_ACTIVE]  = 1'b1;
            end
            default: ;
        endcase
    end

    // Sticky until reset
    always_ff @(posedge clk) begin
        if (reset) err <= '0;
        else       err <= err | err_set_c;
    end
`else
    assign err = '0;

    logic unused_chk_c;
    assign unused_chk_c = ^{bank_active, 32'(TRCD)};
`endif

    // Only burst length 1 exists, so the latched BL and addr[12] never steer anything
    logic unused_c;
    assign unused_c = ^{bl_q, sd_addr[12]};

endmodule
